prio_enc_disp: RTL

- Parametrised successor to the board-level switch priority encoder.
- Synchronises and debounces a WIDTH-bit switch vector, then priority-encodes it with a selectable priority direction.
- Registers index, valid and change-event outputs, with a hold/freeze control.
- Drives two hex seven-segment digits showing the index.
- Sits between board switches and the LED/segment pins in the NPC top level.

---
 rtl/prio_disp_pkg.sv | 33 +++
 rtl/hex7seg.sv | 27 ++
 rtl/prio_enc_disp.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/prio_disp_pkg.sv
// prio_disp_pkg: shared constants for the priority-encoder display block.
//   - Segment bit positions (bit0=a .. bit6=g, bit7=dp).
//   - Active-high 7-bit hex glyphs 0-F (lowercase b and d).
//   - Blank pattern and a helper that applies the pin polarity.
package prio_disp_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Index = nibble value; bit n lights segment n (a..g), active-high.
  localparam logic [6:0] GLYPH_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // All segments dark, before polarity is applied.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Converts an active-high pattern to pin polarity.
  function automatic logic [7:0] seg_apply_pol(input logic [7:0] seg_ah,
                                               input logic       active_low);
    return active_low ? ~seg_ah : seg_ah;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to seven-segment glyph.
// Ports:
//   nib_i      4-bit value to display
//   blank_i    1: all segments dark
//   act_low_i  1: lit segment driven as 0
//   seg_o      {dp, g, f, e, d, c, b, a}; dp is always dark
module hex7seg
  import prio_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  input  logic       act_low_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_ah;

  always_comb begin
    seg_ah = SEG_BLANK;
    if (!blank_i) begin
      seg_ah[SEG_G:SEG_A] = GLYPH_HEX[nib_i];
    end
    seg_ah[SEG_DP] = 1'b0;
    seg_o = seg_apply_pol(seg_ah, act_low_i);
  end

endmodule

// File: rtl/prio_enc_disp.sv
// prio_enc_disp: switch vector synchroniser, debouncer and priority encoder
// with registered index/valid/change outputs and a two-digit hex display.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sw               raw asynchronous switch vector (WIDTH bits)
//   mode             0: highest set bit wins, 1: lowest set bit wins
//   hold             1: freeze idx/valid (and hence the segments)
//   idx, valid       registered encoder result
//   changed          one-cycle pulse after a load that altered idx or valid
//   seg_lo, seg_hi   glyphs of idx[3:0] and idx[7:4]
//   evt_cnt          16-bit count of changed pulses (only with PRIO_EVT_CNT_EN)
// Build option: define PRIO_EVT_CNT_EN to add the evt_cnt output and counter.
module prio_enc_disp
  import prio_disp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEB_CYCLES     = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           sw,
  input  logic                       mode,
  input  logic                       hold,
  output logic [$clog2(WIDTH)-1:0]   idx,
  output logic                       valid,
  output logic                       changed,
  output logic [7:0]                 seg_lo,
  output logic [7:0]                 seg_hi
`ifdef PRIO_EVT_CNT_EN
  ,
  output logic [15:0]                evt_cnt
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  // Wide enough to always hold idx[7:4], zero-filled above IDX_W.
  localparam int PAD_W = (IDX_W > 8) ? IDX_W : 8;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, stable_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] idx_d, idx_q;
  logic             valid_d, valid_q;
  logic             changed_d, changed_q;

  // Synchroniser and debounce. Once a candidate has been seen DEB_CYCLES
  // times in a row, cnt parks at its last value and every further matching
  // sample re-commits the candidate to stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q <= sw;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        stable_q <= cand_q;
      end
    end
  end

  // Priority encode. Each loop lets the last matching bit win, so the scan
  // direction picks highest (ascending) or lowest (descending).
  always_comb begin
    idx_d   = '0;
    valid_d = |stable_q;
    if (mode) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (stable_q[i]) idx_d = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (stable_q[i]) idx_d = IDX_W'(i);
      end
    end
    changed_d = (idx_d != idx_q) || (valid_d != valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else if (hold) begin
      changed_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign idx     = idx_q;
  assign valid   = valid_q;
  assign changed = changed_q;

  logic [PAD_W-1:0] idx_pad;
  logic             hi_blank;

  assign idx_pad  = PAD_W'(idx_q);
  // With 16 or fewer inputs the high digit carries no index bits and stays dark.
  assign hi_blank = !valid_q || (IDX_W <= 4);

  hex7seg u_seg_lo (
    .nib_i     (idx_pad[3:0]),
    .blank_i   (!valid_q),
    .act_low_i (SEG_ACTIVE_LOW),
    .seg_o     (seg_lo)
  );

  hex7seg u_seg_hi (
    .nib_i     (idx_pad[7:4]),
    .blank_i   (hi_blank),
    .act_low_i (SEG_ACTIVE_LOW),
    .seg_o     (seg_hi)
  );

`ifdef PRIO_EVT_CNT_EN
  logic [15:0] evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else if (changed_q) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign evt_cnt = evt_q;
`else
  // No event counter in this build.
`endif

endmodule
